// File: rtl/pwm_core.sv
// pwm_core: double-buffered PWM generator stepped by
// rising edges of an external divider square wave.
module pwm_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick_src,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  input  logic             load,
  output logic             pwm_out,
  output logic             cycle_end,
  output logic             pending,
  output logic [WIDTH-1:0] cnt
);

  logic             s0, s1, s2;
  logic             step;
  logic [WIDTH-1:0] per_act, duty_act;
  logic [WIDTH-1:0] per_stg, duty_stg;

  logic [WIDTH-1:0] cnt_nx;
  logic [WIDTH-1:0] per_act_nx, duty_act_nx;
  logic [WIDTH-1:0] per_stg_nx, duty_stg_nx;
  logic             pend_nx;
  logic             cend_nx;
  logic             pwm_nx;

  assign step = s1 & ~s2;

  // Next-state for counter, active/staged settings and outputs.
  always_comb begin
    cnt_nx      = cnt;
    per_act_nx  = per_act;
    duty_act_nx = duty_act;
    per_stg_nx  = per_stg;
    duty_stg_nx = duty_stg;
    pend_nx     = pending;
    cend_nx     = 1'b0;
    if (!enable) begin
      cnt_nx = '0;
      if (load) begin
        per_act_nx  = period;
        duty_act_nx = duty;
        pend_nx     = 1'b0;
      end
    end else begin
      if (step) begin
        // >= so a shrunken period still wraps
        if (cnt >= per_act) begin
          cnt_nx  = '0;
          cend_nx = 1'b1;
          if (pending) begin
            per_act_nx  = per_stg;
            duty_act_nx = duty_stg;
            pend_nx     = 1'b0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      // load after wrap: wrap takes old staging
      if (load) begin
        per_stg_nx  = period;
        duty_stg_nx = duty;
        pend_nx     = 1'b1;
      end
    end
    pwm_nx = enable & (cnt_nx < duty_act_nx);
  end

  // Edge-detect synchronizer and all registered state.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s0        <= 1'b0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      pwm_out   <= 1'b0;
      cycle_end <= 1'b0;
      pending   <= 1'b0;
      per_act   <= '1;
      duty_act  <= '0;
      per_stg   <= '0;
      duty_stg  <= '0;
    end else begin
      s0        <= tick_src;
      s1        <= s0;
      s2        <= s1;
      cnt       <= cnt_nx;
      pwm_out   <= pwm_nx;
      cycle_end <= cend_nx;
      pending   <= pend_nx;
      per_act   <= per_act_nx;
      duty_act  <= duty_act_nx;
      per_stg   <= per_stg_nx;
      duty_stg  <= duty_stg_nx;
    end
  end

endmodule
